// File: rtl/mul_resp.sv
// mul_resp: two-initiator, fully pipelined 27x27 unsigned multiplier.
//
// Two initiators share one multiplier. A combinational arbiter grants at most
// one request per cycle; the granted operands are multiplied and enter a
// LAT-stage valid/id/product pipeline. Each grant yields exactly one rsp_vld
// pulse LAT cycles later, and responses come back in grant order.
//
// Parameter:
//   LAT            cycles from the grant cycle to rsp_vld (legal range 1..4)
//
// Build option:
//   MUL_RESP_RR_ARB_EN  defined   -> round-robin on a conflict
//                                    (grant the port opposite to `last`)
//                       undefined -> fixed priority, port 0 wins a conflict
//
// Ports:
//   clk                  single clock, rising edge
//   reset                asynchronous active-low reset
//   req0_en              initiator 0 request valid
//   req0_in_1/req0_in_2  initiator 0 operands (27-bit unsigned)
//   req0_gnt             initiator 0 request accepted this cycle
//   req1_*               same signals for initiator 1
//   rsp_vld              product valid this cycle
//   rsp_id               initiator that owns the product
//   rsp_out              54-bit unsigned product (holds its value while rsp_vld is low)
//   busy                 high while any accepted request is still in the pipeline
module mul_resp #(
    parameter int unsigned LAT = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req0_en,
    input  logic [26:0] req0_in_1,
    input  logic [26:0] req0_in_2,
    output logic        req0_gnt,
    input  logic        req1_en,
    input  logic [26:0] req1_in_1,
    input  logic [26:0] req1_in_2,
    output logic        req1_gnt,
    output logic        rsp_vld,
    output logic        rsp_id,
    output logic [53:0] rsp_out,
    output logic        busy
);

    logic        r_last;
    logic [LAT-1:0] r_vld;
    logic [LAT-1:0] r_id;
    logic [53:0] r_prod [LAT];

    logic        w_pick1;
    logic        w_gnt0;
    logic        w_gnt1;
    logic        w_any_gnt;
    logic [26:0] w_op_a;
    logic [26:0] w_op_b;
    logic [53:0] w_prod;

    // Arbitration. w_pick1 says which port wins when both request together.
    // Grants are forced low while reset is asserted.
    always_comb begin
`ifdef MUL_RESP_RR_ARB_EN
        w_pick1 = ~r_last;
`else
        // Fixed priority: port 0 always wins. `last` is still tracked but
        // has no effect on the grant.
        w_pick1 = r_last & 1'b0;
`endif
        w_gnt0    = reset & req0_en & (~req1_en | ~w_pick1);
        w_gnt1    = reset & req1_en & (~req0_en |  w_pick1);
        w_any_gnt = w_gnt0 | w_gnt1;
        w_op_a    = w_gnt1 ? req1_in_1 : req0_in_1;
        w_op_b    = w_gnt1 ? req1_in_2 : req0_in_2;
        // Zero-extend both operands so the product is formed at full width.
        w_prod    = {27'd0, w_op_a} * {27'd0, w_op_b};
    end

    // Pipeline. Stage 0 captures the product on the grant edge; later stages
    // only load data when the stage ahead is valid, so the last stage holds
    // the most recent response while rsp_vld is low.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_last <= 1'b0;
            r_vld  <= '0;
            r_id   <= '0;
            for (int unsigned k = 0; k < LAT; k++) begin
                r_prod[k] <= '0;
            end
        end else begin
            if (w_any_gnt) begin
                r_last    <= w_gnt1;
                r_id[0]   <= w_gnt1;
                r_prod[0] <= w_prod;
            end
            r_vld[0] <= w_any_gnt;
            for (int unsigned k = 1; k < LAT; k++) begin
                r_vld[k] <= r_vld[k-1];
                if (r_vld[k-1]) begin
                    r_id[k]   <= r_id[k-1];
                    r_prod[k] <= r_prod[k-1];
                end
            end
        end
    end

    always_comb begin
        req0_gnt = w_gnt0;
        req1_gnt = w_gnt1;
        rsp_vld  = r_vld[LAT-1];
        rsp_id   = r_id[LAT-1];
        rsp_out  = r_prod[LAT-1];
        busy     = |r_vld;
    end

endmodule

// File: tb/tb_mul_resp.sv
module tb_mul_resp;

    localparam int L2 = 2;
    localparam int L1 = 1;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req0_en = 1'b0, req1_en = 1'b0;
    logic [26:0] req0_in_1 = '0, req0_in_2 = '0, req1_in_1 = '0, req1_in_2 = '0;

    logic        g0, g1, vld, id, bsy;
    logic [53:0] out;
    logic        g0_1, g1_1, vld_1, id_1, bsy_1;
    logic [53:0] out_1;

    always #5 clk = ~clk;

    mul_resp #(.LAT(L2)) u2 (
        .clk(clk), .reset(reset),
        .req0_en(req0_en), .req0_in_1(req0_in_1), .req0_in_2(req0_in_2), .req0_gnt(g0),
        .req1_en(req1_en), .req1_in_1(req1_in_1), .req1_in_2(req1_in_2), .req1_gnt(g1),
        .rsp_vld(vld), .rsp_id(id), .rsp_out(out), .busy(bsy)
    );

    mul_resp #(.LAT(L1)) u1 (
        .clk(clk), .reset(reset),
        .req0_en(req0_en), .req0_in_1(req0_in_1), .req0_in_2(req0_in_2), .req0_gnt(g0_1),
        .req1_en(req1_en), .req1_in_1(req1_in_1), .req1_in_2(req1_in_2), .req1_gnt(g1_1),
        .rsp_vld(vld_1), .rsp_id(id_1), .rsp_out(out_1), .busy(bsy_1)
    );

    typedef struct {
        int          due;
        logic        id;
        logic [53:0] p;
    } exp_t;

    typedef struct {
        logic        e0;
        logic [26:0] a0, b0;
        logic        e1;
        logic [26:0] a1, b1;
        logic [53:0] p0, p1;
    } vec_t;

    exp_t q2[$];
    exp_t q1[$];
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    logic m_last = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s @cyc %0d actual=%h required=%h", nm, cyc, act, exp);
        end
    endtask

    function automatic logic [53:0] mul(input logic [26:0] a, input logic [26:0] b);
        logic [53:0] x, y;
        x = {27'd0, a};
        y = {27'd0, b};
        return x * y;
    endfunction

    // Drive one cycle of stimulus, check all outputs on the falling edge,
    // update the scoreboard, and return just after the next rising edge.
    task automatic drive(input logic e0, input logic [26:0] a0, input logic [26:0] b0,
                         input logic e1, input logic [26:0] a1, input logic [26:0] b1,
                         input logic [53:0] p0, input logic [53:0] p1);
        logic pick1, eg0, eg1, ev;
        exp_t e;
        req0_en = e0; req0_in_1 = a0; req0_in_2 = b0;
        req1_en = e1; req1_in_1 = a1; req1_in_2 = b1;
        @(negedge clk);
`ifdef MUL_RESP_RR_ARB_EN
        pick1 = ~m_last;
`else
        pick1 = 1'b0;
`endif
        eg0 = e0 && (!e1 || !pick1);
        eg1 = e1 && (!e0 || pick1);
        chk("req0_gnt", {63'd0, g0}, {63'd0, eg0});
        chk("req1_gnt", {63'd0, g1}, {63'd0, eg1});
        chk("req0_gnt_lat1", {63'd0, g0_1}, {63'd0, eg0});
        chk("req1_gnt_lat1", {63'd0, g1_1}, {63'd0, eg1});

        ev = (q2.size() != 0) && (q2[0].due == cyc);
        chk("rsp_vld", {63'd0, vld}, {63'd0, ev});
        chk("busy", {63'd0, bsy}, {63'd0, q2.size() != 0});
        if (ev) begin
            chk("rsp_id", {63'd0, id}, {63'd0, q2[0].id});
            chk("rsp_out", {10'd0, out}, {10'd0, q2[0].p});
            void'(q2.pop_front());
        end

        ev = (q1.size() != 0) && (q1[0].due == cyc);
        chk("rsp_vld_lat1", {63'd0, vld_1}, {63'd0, ev});
        chk("busy_lat1", {63'd0, bsy_1}, {63'd0, q1.size() != 0});
        if (ev) begin
            chk("rsp_id_lat1", {63'd0, id_1}, {63'd0, q1[0].id});
            chk("rsp_out_lat1", {10'd0, out_1}, {10'd0, q1[0].p});
            void'(q1.pop_front());
        end

        if (eg0 || eg1) begin
            e.id = eg1;
            e.p  = eg1 ? p1 : p0;
            e.due = cyc + L2;
            q2.push_back(e);
            e.due = cyc + L1;
            q1.push_back(e);
            m_last = eg1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(0, '0, '0, 0, '0, '0, '0, '0);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_rsp_vld"}, {63'd0, vld}, 64'd0);
        chk({tag, "_busy"}, {63'd0, bsy}, 64'd0);
        chk({tag, "_gnt"}, {62'd0, g1, g0}, 64'd0);
        chk({tag, "_rsp_id"}, {63'd0, id}, 64'd0);
        chk({tag, "_rsp_out"}, {10'd0, out}, 64'd0);
        chk({tag, "_lat1_vld_busy"}, {62'd0, vld_1, bsy_1}, 64'd0);
    endtask

    vec_t tbl[8];

    initial begin
        tbl[0] = '{1, 27'd3,          27'd5,         0, 27'd0,         27'd0,         54'd15,               54'd0};
        tbl[1] = '{0, 27'd0,          27'd0,         1, 27'h7FFFFFF,   27'h7FFFFFF,   54'd0,                54'h3FFFFFF0000001};
        tbl[2] = '{1, 27'd0,          27'h7FFFFFF,   0, 27'd0,         27'd0,         54'd0,                54'd0};
        tbl[3] = '{0, 27'd0,          27'd0,         1, 27'd1,         27'd1,         54'd0,                54'd1};
        tbl[4] = '{1, 27'h1000,       27'h1000,      0, 27'd0,         27'd0,         54'h1000000,          54'd0};
        tbl[5] = '{0, 27'd0,          27'd0,         1, 27'h4000000,   27'd2,         54'd0,                54'h8000000};
        tbl[6] = '{0, 27'd0,          27'd0,         0, 27'd0,         27'd0,         54'd0,                54'd0};
        tbl[7] = '{1, 27'd12345,      27'd1000,      0, 27'd0,         27'd0,         54'd12345000,         54'd0};

        // Reset state, with a request pending: grants must stay low.
        req0_en = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        req0_en = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;

        // Single request 3*5 followed by idle cycles (busy/latency check).
        drive(1, 27'd3, 27'd5, 0, '0, '0, 54'd15, '0);
        idle(4);

        // Table vectors, back to back.
        for (int i = 0; i < 8; i++)
            drive(tbl[i].e0, tbl[i].a0, tbl[i].b0, tbl[i].e1, tbl[i].a1, tbl[i].b1, tbl[i].p0, tbl[i].p1);
        idle(4);

        // Reset one cycle after a grant: everything drops, nothing returns.
        drive(1, 27'd9, 27'd9, 0, '0, '0, 54'd81, '0);
        reset = 1'b0;
        #1;
        check_reset_outputs("midreset");
        q2.delete();
        q1.delete();
        m_last = 1'b0;
        req0_en = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        idle(4);

        // Both initiators request for 4 cycles, then req0 drops.
        for (int i = 0; i < 4; i++)
            drive(1, 27'd10, 27'd10, 1, 27'd20, 27'd20, 54'd100, 54'd400);
        drive(0, 27'd10, 27'd10, 1, 27'd20, 27'd20, 54'd100, 54'd400);
        idle(4);

        // Stream of 8 req1 operations against the maximum operand.
        for (int i = 1; i <= 8; i++) begin
            logic [26:0] a;
            a = (i == 8) ? 27'h7FFFFFF : 27'(i);
            drive(0, '0, '0, 1, a, 27'h7FFFFFF, '0, mul(a, 27'h7FFFFFF));
        end
        idle(4);

        chk("scoreboard_drained", 64'(q2.size() + q1.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
